// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - two-requester round-robin front end for a shared fp add/sub datapath
//
// Purpose:
//   Lets two requesters share one combinational single-precision add/sub
//   datapath. A round-robin grant picks one operation, latches its operands
//   and op select onto the datapath and holds them for SETTLE_CYCLES
//   cycles. It then samples the result and the under/overflow flag into a
//   response buffer, which holds its contents until the consumer takes them.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid / reqN_ready         per-requester handshake (N = 0, 1)
//   reqN_op, reqN_a, reqN_b         operation (0 add, 1 a - b) and operands
//   dp_para1, dp_para2, dp_op       registered operands/select to datapath
//   dp_out, dp_under_overflow       combinational datapath result and flag
//   rsp_valid / rsp_ready           response handshake
//   rsp_data, rsp_flag, rsp_id      captured result, flag, issuing requester
//   busy                            operation in flight or response pending

module fp_addsub_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] dp_para1,
  output logic [31:0] dp_para2,
  output logic        dp_op,
  input  logic [31:0] dp_out,
  input  logic        dp_under_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_flag,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic        ptr_q;      // 0: requester 0 wins a tie, 1: requester 1 wins
  logic [3:0]  cnt_q;
  logic        grant_any;
  logic        grant_id;
  logic        sample;
  logic        rsp_done;

  // Grant is only offered in IDLE. Gating with rst_n keeps both readies low
  // while reset is held, so no output is nonzero during reset.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (rst_n && (state_q == IDLE) && (req0_valid || req1_valid)) begin
      grant_any = 1'b1;
      grant_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;

  // A granted requester is valid by construction, so a grant is an accept.
  assign sample   = (state_q == EXEC) && (cnt_q == 4'd0);
  assign rsp_done = (state_q == RESP) && rsp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = EXEC;
      EXEC:    if (sample)    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration pointer and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
      cnt_q <= 4'd0;
    end else if (grant_any) begin
      ptr_q <= !grant_id;
      cnt_q <= CNT_LOAD;
    end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Datapath operand registers: loaded on accept only, so they stay frozen
  // through EXEC and keep the last operation afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_para1 <= 32'd0;
      dp_para2 <= 32'd0;
      dp_op    <= 1'b0;
      rsp_id   <= 1'b0;
    end else if (grant_any) begin
      dp_para1 <= grant_id ? req1_a  : req0_a;
      dp_para2 <= grant_id ? req1_b  : req0_b;
      dp_op    <= grant_id ? req1_op : req0_op;
      rsp_id   <= grant_id;
    end
  end

  // Response buffer: data and flag are only written at the end of EXEC,
  // so they hold under backpressure and after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_flag  <= 1'b0;
    end else if (sample) begin
      rsp_valid <= 1'b1;
      rsp_data  <= dp_out;
      rsp_flag  <= dp_under_overflow;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb/tb_fp_addsub_arbiter.sv - self-checking bench for fp_addsub_arbiter
module tb_fp_addsub_arbiter;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_op = 1'b0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0;
  logic        req1_valid = 1'b0, req1_op = 1'b0;
  logic [31:0] req1_a = 32'd0, req1_b = 32'd0;
  logic        req0_ready, req1_ready;
  logic [31:0] dp_para1, dp_para2, dp_out;
  logic        dp_op, dp_under_overflow;
  logic        rsp_valid, rsp_flag, rsp_id, busy;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;

  int checks = 0;
  int failures = 0;
  int glog[$];

  always #5 clk = ~clk;

  fp_addsub_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .dp_para1(dp_para1), .dp_para2(dp_para2), .dp_op(dp_op),
    .dp_out(dp_out), .dp_under_overflow(dp_under_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flag(rsp_flag), .rsp_id(rsp_id), .busy(busy)
  );

  // Stand-in for the shared IEEE-754 unit: exact results for the directed
  // vectors, an arbitrary deterministic function otherwise.
  function automatic logic [32:0] dp_fn(logic [31:0] a, logic [31:0] b, logic op);
    if (a == 32'h41480000 && b == 32'h40A80000 && op)  return {1'b0, 32'h40E80000};
    if (a == 32'h41A20000 && b == 32'hC14C0000 && !op) return {1'b0, 32'h40F00000};
    if (a == 32'h4504D8B4 && b == 32'h461B13F8 && op)  return {1'b0, 32'hC5F3BB96};
    if (a == 32'h7F7FFFFF && b == 32'hFF7FFFFF && op)  return {1'b1, 32'h7F800000};
    return {1'b0, op ? (a - b) : (a + b)};
  endfunction

  assign {dp_under_overflow, dp_out} = dp_fn(dp_para1, dp_para2, dp_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: the block is either free, working on one
  // recorded operation (age counts cycles since accept), or holding a response.
  bit          m_free, m_resp, m_ptr, m_op, m_id, m_flag;
  int          m_age;
  logic [31:0] m_a, m_b, m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_free = 1; m_resp = 0; m_ptr = 0; m_op = 0; m_id = 0; m_flag = 0;
      m_age = 0; m_a = 0; m_b = 0; m_data = 0;
    end else if (m_resp) begin
      if (rsp_ready) begin m_resp = 0; m_free = 1; end
    end else if (!m_free) begin
      m_age++;
      if (m_age == S) begin
        {m_flag, m_data} = dp_fn(m_a, m_b, m_op);
        m_resp = 1;
      end
    end else if (req0_valid || req1_valid) begin
      m_id  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      m_a   = m_id ? req1_a : req0_a;
      m_b   = m_id ? req1_b : req0_b;
      m_op  = m_id ? req1_op : req0_op;
      m_ptr = !m_id;
      m_age = 0;
      m_free = 0;
    end
  end

  // One compare process, sampling on the falling edge.
  always @(negedge clk) begin
    bit e0, e1;
    e0 = rst_n && m_free && req0_valid && (!req1_valid || !m_ptr);
    e1 = rst_n && m_free && req1_valid && (!req0_valid || m_ptr);
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("ready_excl", 32'(req0_ready && req1_ready), 32'd0);
    chk("busy", 32'(busy), 32'(rst_n && !m_free));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
    chk("dp_para1", dp_para1, m_a);
    chk("dp_para2", dp_para2, m_b);
    chk("dp_op", 32'(dp_op), 32'(m_op));
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_flag", 32'(rsp_flag), 32'(m_flag));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    if (req0_ready && req0_valid) glog.push_back(0);
    if (req1_ready && req1_valid) glog.push_back(1);
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Present one operation and hold it until accepted; returns negedges waited.
  task automatic issue(input bit id, input bit op, input logic [31:0] a,
                       input logic [31:0] b, output int waited);
    bit got;
    got = 0;
    waited = 0;
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (id ? req1_ready : req0_ready) got = 1;
    end
    if (!got) chk("issue_timeout", 32'd1, 32'd0);
    step();
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_rsp(input string name, input logic [31:0] data,
                          input bit flag, input bit id, output int lat);
    bit got;
    got = 0;
    lat = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1;
    end
    if (!got) chk({name, "_timeout"}, 32'd1, 32'd0);
    chk({name, "_data"}, rsp_data, data);
    chk({name, "_flag"}, 32'(rsp_flag), 32'(flag));
    chk({name, "_id"}, 32'(rsp_id), 32'(id));
    step();
  endtask

  initial begin
    int w, lat, seen;
    bit got;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_dp_para1", dp_para1, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    #1 rst_n = 1;
    step();

    // Single subtract, latency pinned to SETTLE_CYCLES.
    issue(0, 1, 32'h41480000, 32'h40A80000, w);
    wait_rsp("sub0", 32'h40E80000, 0, 0, lat);
    chk("sub0_latency", 32'(lat), 32'(S));

    // Requester 1 add then subtract.
    issue(1, 0, 32'h41A20000, 32'hC14C0000, w);
    wait_rsp("add1", 32'h40F00000, 0, 1, lat);
    issue(1, 1, 32'h4504D8B4, 32'h461B13F8, w);
    wait_rsp("sub1", 32'hC5F3BB96, 0, 1, lat);

    // Contention from reset: both valid, expect alternation starting at 0.
    rst_n = 0;
    req0_op = 1; req0_a = 32'h41480000; req0_b = 32'h40A80000; req0_valid = 1;
    req1_op = 0; req1_a = 32'h41A20000; req1_b = 32'hC14C0000; req1_valid = 1;
    step();
    glog.delete();
    rst_n = 1;
    for (int i = 0; i < 200 && glog.size() < 4; i++) @(negedge clk);
    step();
    req0_valid = 0; req1_valid = 0;
    chk("cont_count", 32'(glog.size()), 32'd4);
    if (glog.size() >= 4) begin
      chk("cont_g0", 32'(glog[0]), 32'd0);
      chk("cont_g1", 32'(glog[1]), 32'd1);
      chk("cont_g2", 32'(glog[2]), 32'd0);
      chk("cont_g3", 32'(glog[3]), 32'd1);
    end
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (!busy) got = 1; end
    if (!got) chk("cont_idle_timeout", 32'd1, 32'd0);
    step();

    // Backpressure: response held five cycles while requester 1 waits.
    rsp_ready = 0;
    issue(0, 1, 32'h41480000, 32'h40A80000, w);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (rsp_valid) got = 1; end
    if (!got) chk("bp_timeout", 32'd1, 32'd0);
    step();
    req1_op = 0; req1_a = 32'h41A20000; req1_b = 32'hC14C0000; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", rsp_data, 32'h40E80000);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_no_grant", 32'(req1_ready), 32'd0);
    end
    step();
    rsp_ready = 1;
    issue(1, 0, 32'h41A20000, 32'hC14C0000, w);
    chk("bp_grant_delay", 32'(w), 32'd2);
    wait_rsp("bp_next", 32'h40F00000, 0, 1, lat);

    // Overflow flag capture.
    issue(0, 1, 32'h7F7FFFFF, 32'hFF7FFFFF, w);
    wait_rsp("ovf", 32'h7F800000, 1, 0, lat);

    // Reset mid-EXEC after a req0 accept; pointer must return to req0.
    issue(0, 1, 32'h4504D8B4, 32'h461B13F8, w);
    rst_n = 0;
    step();
    #1;
    chk("rst_dp_para1", dp_para1, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    step();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("rst_no_rsp", 32'(seen), 32'd0);
    step();
    glog.delete();
    req0_op = 0; req0_a = 32'd1; req0_b = 32'd2; req0_valid = 1;
    req1_op = 0; req1_a = 32'd3; req1_b = 32'd4; req1_valid = 1;
    for (int i = 0; i < 20 && glog.size() < 1; i++) @(negedge clk);
    step();
    req0_valid = 0; req1_valid = 0;
    chk("rst_first_grant_count", 32'(glog.size()), 32'd1);
    if (glog.size() >= 1) chk("rst_first_grant", 32'(glog[0]), 32'd0);
    wait_rsp("rst_after", 32'd3, 0, 0, lat);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
